// File: rtl/arm_rf_pkg.sv
// Shared constants for the banked ARM register file: processor modes,
// architecturally special register numbers and NZCV flag bit positions.
package arm_rf_pkg;

    typedef enum logic {
        MODE_USR = 1'b0,
        MODE_IRQ = 1'b1
    } mode_e;

    localparam logic [3:0] REG_SP = 4'd13;
    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/arm_rf_read_port.sv
// One combinational read port: PC view for R15, write-through bypass,
// then the stored register with R13/R14 taken from the current mode's bank.
module arm_rf_read_port
    import arm_rf_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PC_OFFSET = 8
) (
    input  logic [3:0]          addr,
    input  logic                mode,
    input  logic                we,
    input  logic [3:0]          wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W-1:0]   pc_in,
    input  logic [13*DATA_W-1:0] gpr_flat,
    input  logic [DATA_W-1:0]   sp_usr,
    input  logic [DATA_W-1:0]   sp_irq,
    input  logic [DATA_W-1:0]   lr_usr,
    input  logic [DATA_W-1:0]   lr_irq,
    output logic [DATA_W-1:0]   data
);

    // NOTE: data gets a default first so no path through this block infers a latch.
    always_comb begin
        data = '0;
        if (addr == REG_PC) begin
            data = pc_in + DATA_W'(PC_OFFSET);
        end else if (we && (wr_addr == addr)) begin
            data = wr_data;
        end else if (addr == REG_SP) begin
            data = (mode == MODE_IRQ) ? sp_irq : sp_usr;
        end else if (addr == REG_LR) begin
            data = (mode == MODE_IRQ) ? lr_irq : lr_usr;
        end else begin
            data = gpr_flat[DATA_W*int'(addr) +: DATA_W];
        end
    end

endmodule

// File: rtl/arm_banked_regfile.sv
// Register file for the reduced ARM core: shared R0-R12, USR/IRQ banked R13/R14,
// NZCV flags, IRQ mask and SPSR_irq, with IRQ entry and exception return.
module arm_banked_regfile
    import arm_rf_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_RD    = 3,
    parameter int PC_OFFSET = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*4-1:0]      rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we,
    input  logic [3:0]               wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic                     flag_we,
    input  logic [3:0]               flag_in,
    output logic [3:0]               flags,
    input  logic                     imask_we,
    input  logic                     imask_in,
    output logic                     imask,
    input  logic                     irq_req,
    input  logic [DATA_W-1:0]        irq_ret_addr,
    input  logic                     eret,
    output logic                     mode,
    output logic                     irq_taken
);

    logic [DATA_W-1:0]    gpr_q [13];
    logic [DATA_W-1:0]    sp_q  [2];
    logic [DATA_W-1:0]    lr_q  [2];
    logic [13*DATA_W-1:0] gpr_flat;

    mode_e      mode_q, mode_d;
    logic [3:0] flags_q, flags_d;
    logic       imask_q, imask_d;
    logic [4:0] spsr_q, spsr_d;
    logic       irq_taken_q;

    logic       irq_take;
    logic       eret_eff;
    logic [3:0] flags_retire;

    assign irq_take     = irq_req && !imask_q && (mode_q == MODE_USR);
    assign eret_eff     = eret && (mode_q == MODE_IRQ);
    assign flags_retire = flag_we ? flag_in : flags_q;

    always_comb begin
        mode_d = mode_q;
        unique case (mode_q)
            MODE_USR: if (irq_take) mode_d = MODE_IRQ;
            MODE_IRQ: if (eret_eff) mode_d = MODE_USR;
            default:  mode_d = MODE_USR;
        endcase
    end

    // Exception return restores {imask, flags} and drops same-cycle loads of either.
    always_comb begin
        flags_d = flags_retire;
        imask_d = imask_we ? imask_in : imask_q;
        spsr_d  = spsr_q;
        if (irq_take) begin
            imask_d = 1'b1;
            spsr_d  = {imask_q, flags_retire};
        end else if (eret_eff) begin
            {imask_d, flags_d} = spsr_q;
        end
    end

    // NOTE: the register array is reset because software relies on every GPR reading 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 13; i++) gpr_q[i] <= '0;
            for (int b = 0; b < 2; b++) begin
                sp_q[b] <= '0;
                lr_q[b] <= '0;
            end
            mode_q      <= MODE_USR;
            flags_q     <= '0;
            imask_q     <= 1'b1;
            spsr_q      <= '0;
            irq_taken_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            flags_q     <= flags_d;
            imask_q     <= imask_d;
            spsr_q      <= spsr_d;
            irq_taken_q <= irq_take;
            if (we && (wr_addr != REG_PC)) begin
                if (wr_addr == REG_SP)      sp_q[mode_q]   <= wr_data;
                else if (wr_addr == REG_LR) lr_q[mode_q]   <= wr_data;
                else                        gpr_q[wr_addr] <= wr_data;
            end
            // Entry happens only from USR, so a same-cycle R14 write lands in LR_usr.
            if (irq_take) lr_q[MODE_IRQ] <= irq_ret_addr;
        end
    end

    for (genvar g = 0; g < 13; g++) begin : g_flat
        assign gpr_flat[g*DATA_W +: DATA_W] = gpr_q[g];
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        arm_rf_read_port #(
            .DATA_W    (DATA_W),
            .PC_OFFSET (PC_OFFSET)
        ) u_port (
            .addr     (rd_addr[4*k +: 4]),
            .mode     (mode_q),
            .we       (we),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .pc_in    (pc_in),
            .gpr_flat (gpr_flat),
            .sp_usr   (sp_q[MODE_USR]),
            .sp_irq   (sp_q[MODE_IRQ]),
            .lr_usr   (lr_q[MODE_USR]),
            .lr_irq   (lr_q[MODE_IRQ]),
            .data     (rd_data[DATA_W*k +: DATA_W])
        );
    end

    assign flags     = flags_q;
    assign imask     = imask_q;
    assign mode      = mode_q;
    assign irq_taken = irq_taken_q;

endmodule

// File: tb/tb_arm_banked_regfile.sv
// Scoreboard bench for arm_banked_regfile: expectations are queued as stimulus
// is applied and drained against the DUT outputs between clock edges.
module tb_arm_banked_regfile;

    localparam int DATA_W = 32;
    localparam int NUM_RD = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_RD*4-1:0]      rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     we;
    logic [3:0]               wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [DATA_W-1:0]        pc_in;
    logic                     flag_we;
    logic [3:0]               flag_in;
    logic [3:0]               flags;
    logic                     imask_we;
    logic                     imask_in;
    logic                     imask;
    logic                     irq_req;
    logic [DATA_W-1:0]        irq_ret_addr;
    logic                     eret;
    logic                     mode;
    logic                     irq_taken;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef enum {K_REG, K_MODE, K_IMASK, K_FLAGS, K_TAKEN} kind_e;
    typedef struct {
        string       tag;
        kind_e       kind;
        logic [3:0]  addr;
        logic [31:0] exp;
    } sb_entry_t;
    sb_entry_t sb_q[$];

    arm_banked_regfile #(
        .DATA_W    (DATA_W),
        .NUM_RD    (NUM_RD),
        .PC_OFFSET (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .we           (we),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .pc_in        (pc_in),
        .flag_we      (flag_we),
        .flag_in      (flag_in),
        .flags        (flags),
        .imask_we     (imask_we),
        .imask_in     (imask_in),
        .imask        (imask),
        .irq_req      (irq_req),
        .irq_ret_addr (irq_ret_addr),
        .eret         (eret),
        .mode         (mode),
        .irq_taken    (irq_taken)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_reg(input string tag, input logic [3:0] a, input logic [31:0] e);
        sb_entry_t t;
        t.tag = tag; t.kind = K_REG; t.addr = a; t.exp = e;
        sb_q.push_back(t);
    endtask

    task automatic expect_st(input string tag, input kind_e k, input logic [31:0] e);
        sb_entry_t t;
        t.tag = tag; t.kind = k; t.addr = 4'd0; t.exp = e;
        sb_q.push_back(t);
    endtask

    task automatic expect_status(input string pfx, input logic m, input logic im,
                                 input logic [3:0] f, input logic tk);
        expect_st({pfx, "_mode"},  K_MODE,  {31'd0, m});
        expect_st({pfx, "_imask"}, K_IMASK, {31'd0, im});
        expect_st({pfx, "_flags"}, K_FLAGS, {28'd0, f});
        expect_st({pfx, "_taken"}, K_TAKEN, {31'd0, tk});
    endtask

    task automatic expect_zero_regs(input string pfx, input logic [31:0] pc_exp);
        for (int r = 0; r < 15; r++) expect_reg($sformatf("%s_R%0d", pfx, r), 4'(r), 32'd0);
        expect_reg({pfx, "_R15"}, 4'd15, pc_exp);
    endtask

    // Register reads rotate across the read ports so every port is exercised.
    task automatic drain();
        sb_entry_t   e;
        logic [31:0] obs;
        int          p;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = '0;
            case (e.kind)
                K_REG: begin
                    p = int'(e.addr) % NUM_RD;
                    rd_addr[4*p +: 4] = e.addr;
                    #1;
                    obs = rd_data[DATA_W*p +: DATA_W];
                end
                K_MODE:  obs = {31'd0, mode};
                K_IMASK: obs = {31'd0, imask};
                K_FLAGS: obs = {28'd0, flags};
                K_TAKEN: obs = {31'd0, irq_taken};
                default: obs = 'x;
            endcase
            check(e.tag, obs, e.exp);
        end
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        we = 1'b1; wr_addr = a; wr_data = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_v;

        reset = 1'b1; rd_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0;
        pc_in = 32'h100; flag_we = 1'b0; flag_in = '0; imask_we = 1'b0; imask_in = 1'b0;
        irq_req = 1'b0; irq_ret_addr = '0; eret = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        expect_zero_regs("rst", 32'h108);
        expect_status("rst", 1'b0, 1'b1, 4'b0000, 1'b0);
        drain();

        we = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
        expect_reg("bypass_r3", 4'd3, 32'hDEADBEEF);
        expect_reg("nobypass_r4", 4'd4, 32'h0);
        drain();
        tick();
        we = 1'b0;
        expect_reg("stored_r3", 4'd3, 32'hDEADBEEF);
        drain();

        we = 1'b1; wr_addr = 4'd15; wr_data = 32'h12345678;
        expect_reg("pc_over_bypass", 4'd15, 32'h108);
        drain();
        tick();
        we = 1'b0;

        write_reg(4'd13, 32'h11111313);
        write_reg(4'd14, 32'h11111414);
        write_reg(4'd12, 32'hC0DE000C);
        for (int r = 0; r < 16; r++) begin
            case (r)
                3:       exp_v = 32'hDEADBEEF;
                12:      exp_v = 32'hC0DE000C;
                13:      exp_v = 32'h11111313;
                14:      exp_v = 32'h11111414;
                15:      exp_v = 32'h108;
                default: exp_v = 32'h0;
            endcase
            expect_reg($sformatf("sweep_R%0d", r), 4'(r), exp_v);
        end
        drain();

        pc_in = 32'hFFFFFFFC;
        expect_reg("pc_wrap", 4'd15, 32'h4);
        drain();
        pc_in = 32'h100;

        imask_we = 1'b1; imask_in = 1'b0; flag_we = 1'b1; flag_in = 4'b0100;
        tick();
        imask_we = 1'b0; flag_we = 1'b0;
        expect_status("pre_irq", 1'b0, 1'b0, 4'b0100, 1'b0);
        drain();

        irq_req = 1'b1; irq_ret_addr = 32'h2004;
        tick();
        expect_status("irq_entry", 1'b1, 1'b1, 4'b0100, 1'b1);
        expect_reg("lr_irq", 4'd14, 32'h2004);
        expect_reg("sp_irq", 4'd13, 32'h0);
        drain();
        tick();
        expect_status("no_nest", 1'b1, 1'b1, 4'b0100, 1'b0);
        drain();
        irq_req = 1'b0;

        write_reg(4'd13, 32'h55);
        expect_reg("sp_irq_w", 4'd13, 32'h55);
        drain();

        eret = 1'b1; flag_we = 1'b1; flag_in = 4'b1111; imask_we = 1'b1; imask_in = 1'b1;
        tick();
        eret = 1'b0; flag_we = 1'b0; imask_we = 1'b0;
        expect_status("eret", 1'b0, 1'b0, 4'b0100, 1'b0);
        expect_reg("eret_sp_usr", 4'd13, 32'h11111313);
        expect_reg("eret_lr_usr", 4'd14, 32'h11111414);
        drain();

        eret = 1'b1;
        tick();
        eret = 1'b0;
        expect_status("eret_usr", 1'b0, 1'b0, 4'b0100, 1'b0);
        drain();

        irq_req = 1'b1; irq_ret_addr = 32'h3008; flag_we = 1'b1; flag_in = 4'b1001;
        we = 1'b1; wr_addr = 4'd14; wr_data = 32'h22221414; imask_we = 1'b1; imask_in = 1'b0;
        tick();
        irq_req = 1'b0; flag_we = 1'b0; we = 1'b0; imask_we = 1'b0;
        expect_status("entry_flags", 1'b1, 1'b1, 4'b1001, 1'b1);
        expect_reg("entry_lr_irq", 4'd14, 32'h3008);
        expect_reg("entry_sp_irq", 4'd13, 32'h55);
        drain();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        expect_status("eret2", 1'b0, 1'b0, 4'b1001, 1'b0);
        expect_reg("eret2_lr_usr", 4'd14, 32'h22221414);
        drain();

        imask_we = 1'b1; imask_in = 1'b1;
        tick();
        imask_we = 1'b0; irq_req = 1'b1;
        tick();
        tick();
        expect_status("masked", 1'b0, 1'b1, 4'b1001, 1'b0);
        drain();
        irq_req = 1'b0;

        imask_we = 1'b1; imask_in = 1'b0;
        tick();
        imask_we = 1'b0; irq_req = 1'b1; irq_ret_addr = 32'h4000;
        tick();
        irq_req = 1'b0;
        expect_status("entry3", 1'b1, 1'b1, 4'b1001, 1'b1);
        drain();
        reset = 1'b1; we = 1'b1; wr_addr = 4'd5; wr_data = 32'hFFFFFFFF;
        flag_we = 1'b1; flag_in = 4'b1111;
        tick();
        reset = 1'b0; we = 1'b0; flag_we = 1'b0;
        expect_zero_regs("rst2", 32'h108);
        expect_status("rst2", 1'b0, 1'b1, 4'b0000, 1'b0);
        drain();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
